// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory bus between instruction-fetch and data ports.
// One transaction in flight; data has priority, a starvation counter bounds fetch wait.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] I_REQ  = 3'd1;
    localparam logic [2:0] I_WAIT = 3'd2;
    localparam logic [2:0] D_REQ  = 3'd3;
    localparam logic [2:0] D_WAIT = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] starve_cnt;
    logic          i_elig, d_elig, grant_i, grant_d;

    // A port whose valid is high this cycle just completed and must not re-issue.
    assign i_elig  = i_req & ~i_valid;
    assign d_elig  = d_req & ~d_valid;
    assign grant_i = i_elig & (~d_elig | (starve_cnt == CNT_MAX));
    assign grant_d = d_elig & ~grant_i;

    assign i_stall = i_req & ~i_valid;
    assign d_stall = d_req & ~d_valid;
    assign bus_req = (state == I_REQ) | (state == D_REQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_wmask  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state      <= I_REQ;
                        bus_we     <= 1'b0;
                        bus_addr   <= i_addr;
                        bus_wdata  <= '0;
                        bus_wmask  <= '0;
                        starve_cnt <= '0;
                    end else if (grant_d) begin
                        state     <= D_REQ;
                        bus_we    <= d_we;
                        bus_addr  <= d_addr;
                        bus_wdata <= d_wdata;
                        bus_wmask <= d_wmask;
                        if (i_req && starve_cnt != CNT_MAX)
                            starve_cnt <= starve_cnt + CW'(1);
                    end
                end
                I_REQ:  if (bus_gnt) state <= I_WAIT;
                D_REQ:  if (bus_gnt) state <= D_WAIT;
                I_WAIT: begin
                    if (bus_rvalid) begin
                        i_rdata <= bus_rdata;
                        i_valid <= 1'b1;
                        state   <= IDLE;
                    end
                end
                D_WAIT: begin
                    if (bus_rvalid) begin
                        d_rdata <= bus_rdata;
                        d_valid <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small delay-programmable memory responder.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_valid, i_stall;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_valid, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wmask;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wmask;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wmask(bus_wmask), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    // Memory model: grants after gnt_dly cycles of bus_req, completes rv_dly cycles after grant.
    int          gnt_dly = 0;
    int          rv_dly = 0;
    int          phase = 0;
    int          cnt = 0;
    logic        mem_rv;
    logic        inject_rv;
    logic [31:0] resp_data;
    logic [31:0] log_q[$];

    assign bus_rvalid = mem_rv | inject_rv;
    assign bus_rdata  = inject_rv ? 32'h0BAD_0BAD : resp_data;

    initial begin
        bus_gnt = 1'b0;
        mem_rv  = 1'b0;
        forever begin
            @(negedge clk);
            bus_gnt = 1'b0;
            mem_rv  = 1'b0;
            if (phase == 0) begin
                if (bus_req) begin
                    if (cnt >= gnt_dly) begin
                        bus_gnt = 1'b1;
                        log_q.push_back(bus_addr);
                        phase = 1;
                        cnt = 0;
                    end else cnt++;
                end
            end else begin
                if (cnt >= rv_dly) begin
                    mem_rv = 1'b1;
                    phase = 0;
                    cnt = 0;
                end else cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input bit is_d, input string tag);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); #1;
            if (is_d ? d_valid : i_valid) return;
        end
        chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    initial begin
        bit seen;
        reset = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        inject_rv = 1'b0; resp_data = '0;
        repeat (3) step();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_i_valid", i_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_i_rdata", i_rdata, 0);
        reset = 1'b1;
        step();

        // Single fetch, minimum latency.
        resp_data = 32'h0050_0093;
        i_req = 1'b1; i_addr = 32'h100; #1;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) step();
            chk($sformatf("f_bus_req%0d", k), bus_req, 32'(k == 1));
            chk($sformatf("f_i_valid%0d", k), i_valid, 32'(k == 3));
            chk($sformatf("f_i_stall%0d", k), i_stall, 32'(k < 3));
            if (k == 1) begin
                chk("f_bus_addr", bus_addr, 32'h100);
                chk("f_bus_we", bus_we, 0);
                chk("f_bus_wmask", bus_wmask, 0);
            end
        end
        chk("f_i_rdata", i_rdata, 32'h0050_0093);
        i_req = 1'b0;
        step();

        // Store with grant delayed three cycles.
        gnt_dly = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011; #1;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) step();
            chk($sformatf("s_bus_req%0d", k), bus_req, 32'(k >= 1 && k <= 4));
            chk($sformatf("s_d_valid%0d", k), d_valid, 32'(k == 6));
            chk($sformatf("s_d_stall%0d", k), d_stall, 32'(k < 6));
            if (k >= 1 && k <= 4) begin
                chk($sformatf("s_addr%0d", k), bus_addr, 32'h2000);
                chk($sformatf("s_wdata%0d", k), bus_wdata, 32'hDEAD_BEEF);
                chk($sformatf("s_wmask%0d", k), bus_wmask, 32'h3);
                chk($sformatf("s_we%0d", k), bus_we, 1);
            end
        end
        d_req = 1'b0; d_we = 1'b0; gnt_dly = 0;
        step();

        // Starvation: two D wins with fetch pending push the counter to the limit, then fetch wins.
        resp_data = 32'h0000_3333;
        i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_addr = 32'h400;
        step();
        chk("st1_addr", bus_addr, 32'h400);
        chk("st1_cnt", 32'(dut.starve_cnt), 1);
        i_req = 1'b0;
        wait_valid(1'b1, "st1");
        d_req = 1'b0;
        step();
        i_req = 1'b1; d_req = 1'b1; d_addr = 32'h404;
        step();
        chk("st2_addr", bus_addr, 32'h404);
        chk("st2_cnt", 32'(dut.starve_cnt), 2);
        i_req = 1'b0;
        wait_valid(1'b1, "st2");
        d_req = 1'b0;
        step();
        i_req = 1'b1; i_addr = 32'h308; d_req = 1'b1; d_addr = 32'h408;
        step();
        chk("st3_addr", bus_addr, 32'h308);
        chk("st3_cnt", 32'(dut.starve_cnt), 0);
        wait_valid(1'b0, "st3i");
        i_req = 1'b0;
        step();
        chk("st4_req", bus_req, 1);
        chk("st4_addr", bus_addr, 32'h408);
        chk("st4_cnt", 32'(dut.starve_cnt), 0);
        wait_valid(1'b1, "st4");
        chk("st4_rdata", d_rdata, 32'h0000_3333);
        d_req = 1'b0;
        step();

        // Re-issue guard: fetch held across its own valid with a new address.
        log_q.delete();
        i_req = 1'b1; i_addr = 32'h500;
        wait_valid(1'b0, "ri1");
        i_addr = 32'h504;
        wait_valid(1'b0, "ri2");
        i_req = 1'b0;
        repeat (3) step();
        chk("ri_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("ri_addr0", log_q[0], 32'h500);
            chk("ri_addr1", log_q[1], 32'h504);
        end
        chk("ri_idle", bus_req, 0);

        // Reset during D_WAIT, stray completion afterwards.
        resp_data = 32'h7777_7777; rv_dly = 5;
        d_req = 1'b1; d_addr = 32'h600;
        step();
        chk("rs_req", bus_req, 1);
        step();
        chk("rs_wait", bus_req, 0);
        reset = 1'b0; d_req = 1'b0; #1;
        chk("rs_bus_addr", bus_addr, 0);
        chk("rs_d_rdata", d_rdata, 0);
        chk("rs_i_rdata", i_rdata, 0);
        repeat (2) step();
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (d_valid || bus_req) seen = 1'b1;
        end
        chk("rs_no_pulse", seen, 0);
        chk("rs_d_rdata2", d_rdata, 0);
        rv_dly = 0;

        // Spurious completion in IDLE and in I_REQ.
        resp_data = 32'h1111_2222;
        inject_rv = 1'b1;
        step();
        inject_rv = 1'b0;
        chk("sp_idle_rdata", i_rdata, 0);
        chk("sp_idle_valid", i_valid | d_valid, 0);
        gnt_dly = 2;
        i_req = 1'b1; i_addr = 32'h700;
        step();
        inject_rv = 1'b1;
        step();
        inject_rv = 1'b0;
        chk("sp_ireq_req", bus_req, 1);
        chk("sp_ireq_valid", i_valid, 0);
        chk("sp_ireq_rdata", i_rdata, 0);
        wait_valid(1'b0, "sp");
        chk("sp_rdata", i_rdata, 32'h1111_2222);
        i_req = 1'b0; gnt_dly = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
